// File: rtl/fetch_sequencer_19bit.sv
// Fetch/execute sequencer for the 19-bit CPU: drives PC/AR/IR strobes,
// bus select and the memory read handshake, and counts retired instructions.
module fetch_sequencer_19bit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        HALT_REQ,
    input  logic        MEM_ACK,
    input  logic        EXEC_DONE,
    input  logic        BRANCH,
    output logic        PC_LOAD,
    output logic        PC_INC,
    output logic        PC_CLR,
    output logic        AR_LOAD,
    output logic        IR_LOAD,
    output logic        MEM_RD,
    output logic [1:0]  BUS_SEL,
    output logic        EXEC_EN,
    output logic        FAULT,
    output logic [2:0]  STATE,
    output logic [18:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        FETCH_AR  = 3'd2,
        FETCH_MEM = 3'd3,
        DECODE    = 3'd4,
        EXEC      = 3'd5,
        HALTED    = 3'd6
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(MEM_TIMEOUT) - 32'd1;

    state_t      state;
    logic [31:0] wait_cnt;
    logic [18:0] instr_cnt;
    logic        timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);
    assign STATE       = state;
    assign INSTR_CNT   = instr_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            wait_cnt  <= 32'd0;
            FAULT     <= 1'b0;
            instr_cnt <= 19'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) state <= CLEAR;
                end
                CLEAR: begin
                    state <= FETCH_AR;
                end
                FETCH_AR: begin
                    wait_cnt <= 32'd0;
                    state    <= FETCH_MEM;
                end
                FETCH_MEM: begin
                    // An ack arriving in the last allowed cycle beats the timeout
                    if (MEM_ACK) begin
                        state <= DECODE;
                    end else if (timeout_hit) begin
                        FAULT <= 1'b1;
                        state <= HALTED;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (EXEC_DONE) begin
                        instr_cnt <= instr_cnt + 19'd1;
                        state     <= HALT_REQ ? HALTED : FETCH_AR;
                    end
                end
                HALTED: begin
                    if (START) begin
                        FAULT <= 1'b0;
                        state <= FETCH_AR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode from the async-reset state, so they drop with RST at once
    always_comb begin
        PC_LOAD = 1'b0;
        PC_INC  = 1'b0;
        PC_CLR  = 1'b0;
        AR_LOAD = 1'b0;
        IR_LOAD = 1'b0;
        MEM_RD  = 1'b0;
        BUS_SEL = 2'b00;
        EXEC_EN = 1'b0;
        case (state)
            CLEAR: begin
                PC_CLR = 1'b1;
            end
            FETCH_AR: begin
                AR_LOAD = 1'b1;
                BUS_SEL = 2'b01;
            end
            FETCH_MEM: begin
                MEM_RD  = 1'b1;
                BUS_SEL = 2'b10;
                IR_LOAD = MEM_ACK;
                PC_INC  = MEM_ACK;
            end
            EXEC: begin
                EXEC_EN = 1'b1;
                if (EXEC_DONE && BRANCH) begin
                    PC_LOAD = 1'b1;
                    BUS_SEL = 2'b11;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer_19bit.sv
// Scoreboard bench for fetch_sequencer_19bit: per-cycle input/expected
// output pairs are queued, then replayed and compared cycle by cycle.
module tb_fetch_sequencer_19bit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START, HALT_REQ, MEM_ACK, EXEC_DONE, BRANCH;
    logic        PC_LOAD, PC_INC, PC_CLR, AR_LOAD, IR_LOAD, MEM_RD;
    logic [1:0]  BUS_SEL;
    logic        EXEC_EN, FAULT;
    logic [2:0]  STATE;
    logic [18:0] INSTR_CNT;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    logic [4:0]  stim_q[$];
    logic [12:0] exp_q[$];
    logic [12:0] obs;

    fetch_sequencer_19bit #(.MEM_TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .HALT_REQ(HALT_REQ),
        .MEM_ACK(MEM_ACK), .EXEC_DONE(EXEC_DONE), .BRANCH(BRANCH),
        .PC_LOAD(PC_LOAD), .PC_INC(PC_INC), .PC_CLR(PC_CLR),
        .AR_LOAD(AR_LOAD), .IR_LOAD(IR_LOAD), .MEM_RD(MEM_RD),
        .BUS_SEL(BUS_SEL), .EXEC_EN(EXEC_EN), .FAULT(FAULT),
        .STATE(STATE), .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    assign obs = {STATE, PC_LOAD, PC_INC, PC_CLR, AR_LOAD, IR_LOAD,
                  MEM_RD, BUS_SEL, EXEC_EN, FAULT};

    // inputs: {START, HALT_REQ, MEM_ACK, EXEC_DONE, BRANCH}
    localparam logic [4:0] I_NONE  = 5'b00000;
    localparam logic [4:0] I_START = 5'b10000;
    localparam logic [4:0] I_ACK   = 5'b00100;
    localparam logic [4:0] I_DONE  = 5'b00010;
    localparam logic [4:0] I_TIED  = 5'b00110;

    // strobes: {PC_LOAD, PC_INC, PC_CLR, AR_LOAD, IR_LOAD, MEM_RD}
    function automatic logic [12:0] ev(input logic [2:0] st,
                                       input logic [5:0] str,
                                       input logic [1:0] bus,
                                       input logic en, input logic f);
        return {st, str, bus, en, f};
    endfunction

    function automatic logic [12:0] v_fetch_ar(input logic f);
        return ev(3'd2, 6'b000100, 2'b01, 1'b0, f);
    endfunction

    function automatic logic [12:0] v_halted(input logic f);
        return ev(3'd6, 6'b000000, 2'b00, 1'b0, f);
    endfunction

    localparam logic [12:0] V_IDLE  = 13'd0;
    localparam logic [12:0] V_CLEAR = {3'd1, 6'b001000, 2'b00, 1'b0, 1'b0};
    localparam logic [12:0] V_WAIT  = {3'd3, 6'b000001, 2'b10, 1'b0, 1'b0};
    localparam logic [12:0] V_ACK   = {3'd3, 6'b010011, 2'b10, 1'b0, 1'b0};
    localparam logic [12:0] V_DEC   = {3'd4, 6'b000000, 2'b00, 1'b0, 1'b0};
    localparam logic [12:0] V_EXEC  = {3'd5, 6'b000000, 2'b00, 1'b1, 1'b0};
    localparam logic [12:0] V_EXBR  = {3'd5, 6'b100000, 2'b11, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] in, input logic [12:0] e);
        stim_q.push_back(in);
        exp_q.push_back(e);
    endtask

    task automatic run();
        logic [4:0] in;
        while (stim_q.size() > 0) begin
            in = stim_q.pop_front();
            {START, HALT_REQ, MEM_ACK, EXEC_DONE, BRANCH} = in;
            #1;
            check($sformatf("cyc%0d", cyc_n), 32'(obs), 32'(exp_q.pop_front()));
            cyc_n++;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        {START, HALT_REQ, MEM_ACK, EXEC_DONE, BRANCH} = I_NONE;
        RST = 1'b1;
        #2;
        check("rst_vec", 32'(obs), 32'(V_IDLE));
        check("rst_cnt", 32'(INSTR_CNT), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // back-to-back 4-cycle instructions
        push(I_START, V_IDLE);
        push(I_TIED, V_CLEAR);
        for (int i = 0; i < 5; i++) begin
            push(I_TIED, v_fetch_ar(1'b0));
            push(I_TIED, V_ACK);
            push(I_TIED, V_DEC);
            push(I_TIED, V_EXEC);
        end
        run();
        check("cnt_after5", 32'(INSTR_CNT), 32'd5);

        // three wait cycles on memory
        push(I_NONE, v_fetch_ar(1'b0));
        for (int i = 0; i < 3; i++) push(I_NONE, V_WAIT);
        push(I_ACK, V_ACK);
        push(I_NONE, V_DEC);
        push(I_DONE, V_EXEC);
        run();
        check("cnt_delay", 32'(INSTR_CNT), 32'd6);

        // timeout, then resume without PC clear
        push(I_NONE, v_fetch_ar(1'b0));
        for (int i = 0; i < 16; i++) push(I_NONE, V_WAIT);
        push(I_ACK, v_halted(1'b1));
        push(I_START, v_halted(1'b1));
        push(I_NONE, v_fetch_ar(1'b0));
        // ack in the 16th wait cycle beats the timeout
        for (int i = 0; i < 15; i++) push(I_NONE, V_WAIT);
        push(I_ACK, V_ACK);
        push(I_NONE, V_DEC);
        push(5'b01001, V_EXEC);
        push(5'b01011, V_EXBR);
        run();
        check("cnt_branch", 32'(INSTR_CNT), 32'd7);
        check("halt_state", 32'(STATE), 32'd6);

        // counter wrap
        dut.instr_cnt = 19'h7FFFF;
        push(I_START, v_halted(1'b0));
        push(I_NONE, v_fetch_ar(1'b0));
        push(I_ACK, V_ACK);
        push(I_NONE, V_DEC);
        push(I_DONE, V_EXEC);
        run();
        check("cnt_wrap", 32'(INSTR_CNT), 32'd0);

        // one more instruction, then reset mid-read
        push(I_NONE, v_fetch_ar(1'b0));
        push(I_ACK, V_ACK);
        push(I_NONE, V_DEC);
        push(I_DONE, V_EXEC);
        push(I_NONE, v_fetch_ar(1'b0));
        push(I_NONE, V_WAIT);
        run();
        check("pre_rst_rd", 32'(MEM_RD), 32'd1);
        check("pre_rst_cnt", 32'(INSTR_CNT), 32'd1);
        RST = 1'b1;
        #1;
        check("rst_async_rd", 32'(MEM_RD), 32'd0);
        check("rst_async_st", 32'(STATE), 32'd0);
        check("rst_async_cnt", 32'(INSTR_CNT), 32'd0);
        check("rst_async_vec", 32'(obs), 32'(V_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer_19bit.md
# fetch_sequencer_19bit

Instruction-fetch and execute sequencer for the 19-bit CPU. It issues the `LOAD`/`INC`/`CLR` strobes that the 19-bit registers (PC, AR, IR) consume, selects the bus source, and runs a read handshake with memory. It also hands off each instruction to the execution unit and counts retired instructions. It sits between the register bank and the memory and execute datapath, and drives register control rather than holding data.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles `MEM_RD` waits for `MEM_ACK`; 0 disables the timeout.
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RST` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `START` input 1: begin run from IDLE, or resume from HALTED.
- `HALT_REQ` input 1: stop after the current instruction retires.
- `MEM_ACK` input 1: memory read data valid on bus.
- `EXEC_DONE` input 1: execution unit finished current instruction.
- `BRANCH` input 1: sampled with `EXEC_DONE`; load PC from execute bus.
- `PC_LOAD`, `PC_INC`, `PC_CLR` output 1 each: PC register strobes.
- `AR_LOAD` output 1: AR register load strobe.
- `IR_LOAD` output 1: IR register load strobe.
- `MEM_RD` output 1: memory read request.
- `BUS_SEL` output 2: 00 none, 01 PC, 10 memory, 11 execute unit.
- `EXEC_EN` output 1: execution unit enable.
- `FAULT` output 1: memory timeout occurred (sticky).
- `STATE` output 3: current state encoding.
- `INSTR_CNT` output 19: retired-instruction count.

## Operation
- States and encodings: IDLE=0, CLEAR=1, FETCH_AR=2, FETCH_MEM=3, DECODE=4, EXEC=5, HALTED=6. Encoding 7 is unreachable and recovers to IDLE.
- **IDLE**: all strobes 0.
  - `START`=1 → CLEAR.
- **CLEAR**: `PC_CLR`=1 for 1 cycle → FETCH_AR.
- **FETCH_AR**: `BUS_SEL`=01, `AR_LOAD`=1 for 1 cycle → FETCH_MEM.
- **FETCH_MEM**: `MEM_RD`=1 and `BUS_SEL`=10 are held every cycle.
  - In a cycle with `MEM_ACK`=1: `IR_LOAD`=1 and `PC_INC`=1 in that same cycle (combinational from state and `MEM_ACK`) → DECODE.
  - The wait counter starts at 0 on entry and increments each cycle without ack.
  - If `MEM_ACK`=0 and the counter = `MEM_TIMEOUT`−1: set `FAULT` → HALTED, with no `IR_LOAD`.
- **DECODE**: all strobes 0 for 1 cycle (IR settle) → EXEC.
- **EXEC**: `EXEC_EN`=1 until `EXEC_DONE`=1.
  - In the `EXEC_DONE` cycle: if `BRANCH`=1, `PC_LOAD`=1 and `BUS_SEL`=11 in that cycle.
  - `INSTR_CNT` increments (wraps 0x7FFFF→0).
  - Next state: HALTED if `HALT_REQ`=1, else FETCH_AR.
- **HALTED**: all strobes 0.
  - `START`=1 clears `FAULT` → FETCH_AR. PC is not cleared on resume.
- Strobe exclusivity: at most one of `PC_LOAD`/`PC_INC`/`PC_CLR` is high in any cycle. `AR_LOAD` and `IR_LOAD` are never high together.
- Inputs outside their states are ignored:
  - `START` outside IDLE/HALTED.
  - `MEM_ACK` outside FETCH_MEM.
  - `EXEC_DONE`/`BRANCH` outside EXEC.
  - `HALT_REQ` is sampled only on the `EXEC_DONE` cycle.

## Timing
- Reset values: state IDLE, `STATE`=0, `INSTR_CNT`=0, `FAULT`=0, wait counter 0.
  - All strobes, `MEM_RD`, `EXEC_EN` are 0 and `BUS_SEL`=00, and they go low immediately on `RST` assertion, without waiting for a clock edge.
- Start latency: `START` sampled at edge n → `PC_CLR` during cycle n+1, `AR_LOAD` during cycle n+2, `MEM_RD` from cycle n+3.
- Minimum instruction period with ack on the first `MEM_RD` cycle and `EXEC_DONE` on the first EXEC cycle: 4 cycles (FETCH_AR, FETCH_MEM, DECODE, EXEC).
- Memory wait: each cycle without ack adds 1 cycle. The timeout fires in the `MEM_TIMEOUT`-th cycle of FETCH_MEM; an ack in that same cycle wins over the timeout.
- `BRANCH` and `HALT_REQ` together: `PC_LOAD` is still issued, the count increments, then HALTED.
- `RST` mid-FETCH_MEM or mid-EXEC: the transaction is abandoned, with no `IR_LOAD`/`PC_INC`/count change.

## Test plan
- Reset then `START` pulse, `MEM_ACK` tied 1, `EXEC_DONE` tied 1 → `PC_CLR` at cycle 1; then a repeating 4-cycle pattern `AR_LOAD`, `MEM_RD`+`IR_LOAD`+`PC_INC`, idle, `EXEC_EN`; `INSTR_CNT`=5 after 20 cycles from `AR_LOAD`.
- Memory delay 3 cycles → `MEM_RD` high 4 cycles, `IR_LOAD` only in the 4th; instruction period 7.
- `MEM_TIMEOUT`=16, `MEM_ACK`=0 → `FAULT`=1 and `STATE`=6 after exactly 16 FETCH_MEM cycles, no `IR_LOAD`. `START` → `FAULT`=0, `AR_LOAD` next cycle, no `PC_CLR`.
- `EXEC_DONE`, `BRANCH`, `HALT_REQ` all 1 in one cycle → `PC_LOAD`=1 with `BUS_SEL`=11 in that cycle, `INSTR_CNT` +1, `STATE`=6.
- Force `INSTR_CNT` to 0x7FFFF (run or preload via hierarchy) then retire one instruction → 0.
- Assert `RST` while `MEM_RD`=1 → `MEM_RD`=0 and `STATE`=0 before the next edge; `INSTR_CNT`=0.
